// File: rtl/conv_sched_pkg.sv
// conv_sched_pkg: shared state encoding and default tile geometry for the conv layer scheduler
package conv_sched_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_WB, DONE} state_t;
  localparam int DEF_CW        = 8;
  localparam int DEF_OC_TILES  = 4;
  localparam int DEF_ROW_TILES = 8;
  localparam int DEF_IC_CHUNKS = 6;
endpackage

// File: rtl/conv_layer_sched_loop_cnt.sv
// sched_loop_cnt: nested row (inner) / output-channel (outer) tile counter with final-tile flag
module sched_loop_cnt #(
  parameter int ROWS = 8,
  parameter int OCS  = 4,
  parameter int W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] row_o,
  output logic [W-1:0] oc_o,
  output logic         last_o
);
  logic [W-1:0] row_q, row_d, oc_q, oc_d;
  logic         row_max;
  // row wraps into an oc increment; clear has priority over increment
  always_comb begin
    row_max = row_q == W'(ROWS - 1);
    row_d   = clr_i ? '0 : inc_i ? (row_max ? '0 : row_q + W'(1)) : row_q;
    oc_d    = clr_i ? '0 : (inc_i && row_max) ? oc_q + W'(1) : oc_q;
    last_o  = row_max && (oc_q == W'(OCS - 1));
  end
  // tile position registers
  always_ff @(posedge clk) begin
    if (rst) begin
      row_q <= '0;
      oc_q  <= '0;
    end else begin
      row_q <= row_d;
      oc_q  <= oc_d;
    end
  end
  assign row_o = row_q;
  assign oc_o  = oc_q;
endmodule

// File: rtl/conv_layer_sched.sv
// conv_layer_sched: walks oc/row/ic tile loops issuing PE commands; CONV_SCHED_PERF_EN adds perf counters
module conv_layer_sched
  import conv_sched_pkg::*;
#(
  parameter int OC_TILES  = DEF_OC_TILES,
  parameter int ROW_TILES = DEF_ROW_TILES,
  parameter int IC_CHUNKS = DEF_IC_CHUNKS,
  parameter int CW        = DEF_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          halt,
  output logic          issue_v,
  input  logic          issue_rdy,
  output logic [CW-1:0] issue_oc,
  output logic [CW-1:0] issue_row,
  output logic [CW-1:0] issue_ic,
  output logic          issue_first,
  output logic          issue_last,
  input  logic          wb_done,
  output logic          busy,
  output logic          layer_done,
  output logic [31:0]   perf_busy_cyc,
  output logic [31:0]   perf_halt_cyc
);
  state_t        state_q, state_d;
  logic [CW-1:0] ic_q, ic_d;
  logic          held_q, held_d;
  logic          cnt_clr, cnt_inc, tile_last, ic_max, start_acc;
  sched_loop_cnt #(.ROWS(ROW_TILES), .OCS(OC_TILES), .W(CW)) u_loop (
    .clk   (clk),
    .rst   (rst),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .row_o (issue_row),
    .oc_o  (issue_oc),
    .last_o(tile_last)
  );
  // held_q keeps a raised valid up until accepted so halt can never withdraw it
  always_comb begin
    state_d   = state_q;
    ic_d      = ic_q;
    held_d    = 1'b0;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    ic_max    = ic_q == CW'(IC_CHUNKS - 1);
    start_acc = (state_q == IDLE) && start;
    issue_v   = (state_q == ISSUE) && (held_q || !halt);
    unique case (state_q)
      IDLE: if (start) begin
        state_d = ISSUE;
        ic_d    = '0;
        cnt_clr = 1'b1;
      end
      ISSUE: begin
        held_d = issue_v && !issue_rdy;
        if (issue_v && issue_rdy) begin
          state_d = ic_max ? WAIT_WB : ISSUE;
          ic_d    = ic_max ? '0 : ic_q + CW'(1);
        end
      end
      WAIT_WB: if (wb_done) begin
        state_d = tile_last ? DONE : ISSUE;
        cnt_inc = !tile_last;
      end
      DONE: state_d = IDLE;
    endcase
  end
  // FSM state, inner chunk index and valid-hold flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ic_q    <= '0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ic_q    <= ic_d;
      held_q  <= held_d;
    end
  end
  assign issue_ic    = ic_q;
  assign issue_first = issue_v && (ic_q == '0);
  assign issue_last  = issue_v && ic_max;
  assign busy        = state_q != IDLE;
  assign layer_done  = state_q == DONE;
`ifdef CONV_SCHED_PERF_EN
  logic [31:0] pbusy_q, phalt_q;
  // saturating activity counters, cleared at each accepted start
  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      pbusy_q <= '0;
      phalt_q <= '0;
    end else begin
      if (busy && !(&pbusy_q)) pbusy_q <= pbusy_q + 32'd1;
      if (busy && halt && !(&phalt_q)) phalt_q <= phalt_q + 32'd1;
    end
  end
  assign perf_busy_cyc = pbusy_q;
  assign perf_halt_cyc = phalt_q;
`else
  assign perf_busy_cyc = '0;
  assign perf_halt_cyc = '0;
`endif
endmodule
